rc4_encrypt: RTL
================

// Module: rc4_encrypt
// PURPOSE
//  Transmit-side RC4 stream cipher: loads a byte-serial key, runs KSA, then XORs each plaintext
//  byte with the next PRGA keystream byte. Self-contained keystream engine, byte-compatible with
//  the team's decrypt path for the same key. Sits between the framer and the channel modulator.
// PARAMETERS
//  KEY_LEN  3  key length in bytes (1..16); KSA uses key[i mod KEY_LEN]
//  DROP_N   0  keystream bytes discarded after KSA (RC4-dropN); 0..1023
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous reset, active-low (rst==0 at a clk edge resets)
//  key_in     in   8  key byte
//  key_valid  in   1  key_in valid; accepted when key_valid && key_ready
//  key_ready  out  1  high in LOAD state
//  rekey      in   1  one-cycle pulse: abort, return to LOAD
//  pt_data    in   8  plaintext byte
//  pt_valid   in   1  plaintext valid
//  pt_ready   out  1  plaintext accepted when pt_valid && pt_ready
//  ct_data    out  8  ciphertext byte = pt_data ^ K
//  ct_valid   out  1  ct_data valid; held until ct_ready
//  ct_ready   in   1  downstream accept
//  init_done  out  1  high while in RUN (keystream ready)
// BEHAVIOUR
//  Reset: state=LOAD, i=j=0, kcnt=0, ct_valid=0, ct_data=0, init_done=0, pt_ready=0;
//   key_ready forced 0 while rst==0, 1 from first cycle after release.
//  FSM: LOAD -> INIT -> KSA -> DROP -> RUN. DROP skipped when DROP_N==0.
//  LOAD: store key byte kcnt, kcnt++; after KEY_LEN-th accept -> INIT next cycle.
//  INIT: 256 cycles, S[n]=n for n=0..255 (one per cycle); then j=0 -> KSA.
//  KSA: 256 cycles, n=0..255: j=j+S[n]+key[n mod KEY_LEN] (mod 256), swap S[n],S[j].
//   Exit: i=0, j=0.
//  DROP: DROP_N cycles, one PRGA step each, keystream discarded.
//  RUN: init_done=1; pt_ready = !ct_valid || ct_ready (1-entry output reg, full throughput).
//  PRGA step (one cycle): i'=i+1; j'=j+S[i']; swap S[i'],S[j']; t=S[i']+S[j'] (old values,
//   mod 256); K = S[j'] if t==i', S[i'] if t==j', else S[t] (post-swap value, bypassed).
//   i'==j' -> swap is a no-op, K=S[t].
//  PRGA advances ONLY on pt accept; ct_data/ct_valid registered, latency 1 cycle.
//  ct_valid && !ct_ready: ct_data stable, pt_ready=0, no PRGA step.
//  Simultaneous ct_ready && pt accept: new byte loaded, ct_valid stays 1.
//  All 8-bit index/sum arithmetic wraps mod 256; kidx wraps at KEY_LEN.
//  Total latency last key byte -> init_done: 512 + DROP_N cycles.
//  rekey (any state): next cycle state=LOAD, kcnt=0, ct_valid=0, init_done=0; pending ct lost.
//   rekey wins over a same-cycle key or pt accept (which is ignored).
//  key_valid outside LOAD ignored; pt_valid outside RUN ignored (pt_ready=0).
//  Reset mid-operation: identical to power-up reset; key and S contents invalidated.
// STRUCTURE
//  rc4_pkg: localparams SBOX_DEPTH=256, state enum {LOAD,INIT,KSA,DROP,RUN}, MAX_KEY_LEN=16.
//  Sub-module rc4_sbox: 256x8 flop array, 3 async read ports (i', j', t), 2 sync write
//   ports for swap (write i' and j' same cycle; equal addresses -> single write), init-fill
//   mode. Top holds FSM, key register file, i/j/kcnt/drop counters, XOR and output register.
// TESTING
//  1 KEY_LEN=3 key "Key", pt "Plaintext" -> ct BB F3 16 E8 D9 40 AF 0A D3; init_done
//    exactly 512 cycles after 3rd key accept.
//  2 KEY_LEN=4 key "Wiki", pt "pedia" -> ct 10 21 BF 04 20; KEY_LEN=6 "Secret",
//    pt "Attack at dawn" -> 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
//  3 Backpressure: test 1 with ct_ready random 50% -> same ct sequence, no drop/duplicate,
//    ct_data stable while stalled; pt stream continuous -> 1 byte/cycle with ct_ready=1.
//  4 DROP_N=3, key "Key", pt 00x9 -> ct = keystream bytes 3..11 of key "Key" (starts 81 B7 34).
//  5 rekey pulse after 4 bytes of test 1, reload "Key" -> ct restarts at BB; ct_valid
//    low cycle after rekey.
//  6 rst=0 asserted mid-KSA for 1 cycle -> all outputs 0, key_ready=1 next cycle,
//    full rerun of test 1 passes.

Source files
------------

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared constants, FSM state encoding and keystream-select
//                helper for the RC4 transmit cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

  localparam int SBOX_DEPTH  = 256;
  localparam int MAX_KEY_LEN = 16;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_INIT = 3'd1,
    ST_KSA  = 3'd2,
    ST_DROP = 3'd3,
    ST_RUN  = 3'd4
  } rc4_state_e;

  // Keystream byte S_new[t] after the i'/j' swap, taken from pre-swap reads:
  // the two swapped slots are bypassed, every other slot is unchanged.
  function automatic logic [7:0] rc4_select_k(
    input logic [7:0] t,
    input logic [7:0] ii,
    input logic [7:0] jj,
    input logic [7:0] s_ii,
    input logic [7:0] s_jj,
    input logic [7:0] s_t
  );
    logic [7:0] k;
    if (t == ii)      k = s_jj;
    else if (t == jj) k = s_ii;
    else              k = s_t;
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_sbox
//  Description : 256x8 RC4 permutation state. Three asynchronous read ports
//                (i', j', t), a two-port synchronous swap write and an
//                identity fill mode used during initialisation.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       fill_en_i,
  input  logic [7:0] fill_addr_i,
  input  logic       swap_en_i,
  input  logic [7:0] addr_a_i,
  input  logic [7:0] addr_b_i,
  input  logic [7:0] addr_t_i,
  input  logic [7:0] wdata_a_i,
  input  logic [7:0] wdata_b_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o,
  output logic [7:0] rdata_t_o
);

  logic [7:0] mem_q [SBOX_DEPTH];

  assign rdata_a_o = mem_q[addr_a_i];
  assign rdata_b_o = mem_q[addr_b_i];
  assign rdata_t_o = mem_q[addr_t_i];

  // Per-entry write: fill has priority; on a swap with equal addresses port A
  // wins, which is a single write of the unchanged value.
  always_ff @(posedge clk) begin
    for (int n = 0; n < SBOX_DEPTH; n++) begin
      if (fill_en_i && (fill_addr_i == 8'(n))) begin
        mem_q[n] <= 8'(n);
      end else if (swap_en_i && (addr_a_i == 8'(n))) begin
        mem_q[n] <= wdata_a_i;
      end else if (swap_en_i && (addr_b_i == 8'(n))) begin
        mem_q[n] <= wdata_b_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc4_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_encrypt
//  Description : Transmit-side RC4 stream cipher. Loads a byte-serial key,
//                runs KSA (plus optional drop-N), then XORs each accepted
//                plaintext byte with the next PRGA keystream byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_encrypt #(
  parameter int KEY_LEN = 3,
  parameter int DROP_N  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       rekey,
  input  logic [7:0] pt_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  output logic [7:0] ct_data,
  output logic       ct_valid,
  input  logic       ct_ready,
  output logic       init_done
);
  import rc4_pkg::*;

  localparam logic [3:0] KEY_LAST  = 4'(KEY_LEN - 1);
  localparam logic [9:0] DROP_LAST = 10'((DROP_N > 0) ? (DROP_N - 1) : 0);

  rc4_state_e state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [3:0] kcnt_q, kcnt_d;
  logic [3:0] kidx_q, kidx_d;
  logic [9:0] drop_q, drop_d;
  logic       ct_valid_q, ct_valid_d;
  logic [7:0] ct_data_q, ct_data_d;
  logic [7:0] key_q [MAX_KEY_LEN];

  logic       key_acc, pt_acc, ksa_mode;
  logic       fill_en, swap_en;
  logic [7:0] addr_a, j_sum, addr_t;
  logic [7:0] s_a, s_b, s_t, ks_byte;

  assign key_ready = rst && (state_q == ST_LOAD);
  assign pt_ready  = rst && (state_q == ST_RUN) && (!ct_valid_q || ct_ready);
  assign init_done = (state_q == ST_RUN);
  assign ct_valid  = ct_valid_q;
  assign ct_data   = ct_data_q;

  // rekey takes precedence over any handshake in the same cycle
  assign key_acc = key_valid && key_ready && !rekey;
  assign pt_acc  = pt_valid && pt_ready && !rekey;

  // KSA walks S[n] at n=i; PRGA (drop and run) works on i'=i+1.
  assign ksa_mode = (state_q == ST_KSA);
  assign addr_a   = ksa_mode ? i_q : (i_q + 8'd1);
  assign j_sum    = j_q + s_a + (ksa_mode ? key_q[kidx_q] : 8'd0);
  assign addr_t   = s_a + s_b;
  assign ks_byte  = rc4_select_k(addr_t, addr_a, j_sum, s_a, s_b, s_t);

  rc4_sbox u_sbox (
    .clk         (clk),
    .fill_en_i   (fill_en),
    .fill_addr_i (i_q),
    .swap_en_i   (swap_en),
    .addr_a_i    (addr_a),
    .addr_b_i    (j_sum),
    .addr_t_i    (addr_t),
    .wdata_a_i   (s_b),
    .wdata_b_i   (s_a),
    .rdata_a_o   (s_a),
    .rdata_b_o   (s_b),
    .rdata_t_o   (s_t)
  );

  // Key register file: byte kcnt is captured on each accepted key beat.
  always_ff @(posedge clk) begin
    if (key_acc) key_q[kcnt_q] <= key_in;
  end

  // State, counters and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      kcnt_q     <= 4'd0;
      kidx_q     <= 4'd0;
      drop_q     <= 10'd0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kcnt_q     <= kcnt_d;
      kidx_q     <= kidx_d;
      drop_q     <= drop_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
    end
  end

  // Next-state, counter and S-box control decode.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    kcnt_d     = kcnt_q;
    kidx_d     = kidx_q;
    drop_d     = drop_q;
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    fill_en    = 1'b0;
    swap_en    = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (key_acc) begin
          if (kcnt_q == KEY_LAST) begin
            state_d = ST_INIT;
            kcnt_d  = 4'd0;
            i_d     = 8'd0;
          end else begin
            kcnt_d  = kcnt_q + 4'd1;
          end
        end
      end
      ST_INIT: begin
        fill_en = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = ST_KSA;
          j_d     = 8'd0;
          kidx_d  = 4'd0;
        end
      end
      ST_KSA: begin
        swap_en = 1'b1;
        i_d     = i_q + 8'd1;
        j_d     = j_sum;
        kidx_d  = (kidx_q == KEY_LAST) ? 4'd0 : (kidx_q + 4'd1);
        if (i_q == 8'hFF) begin
          state_d = (DROP_N == 0) ? ST_RUN : ST_DROP;
          i_d     = 8'd0;
          j_d     = 8'd0;
          drop_d  = 10'd0;
        end
      end
      ST_DROP: begin
        swap_en = 1'b1;
        i_d     = addr_a;
        j_d     = j_sum;
        drop_d  = drop_q + 10'd1;
        if (drop_q == DROP_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pt_acc) begin
          swap_en    = 1'b1;
          i_d        = addr_a;
          j_d        = j_sum;
          ct_data_d  = pt_data ^ ks_byte;
          ct_valid_d = 1'b1;
        end else if (ct_ready) begin
          ct_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    if (rekey) begin
      state_d    = ST_LOAD;
      kcnt_d     = 4'd0;
      i_d        = 8'd0;
      j_d        = 8'd0;
      ct_valid_d = 1'b0;
      fill_en    = 1'b0;
      swap_en    = 1'b0;
    end
  end

endmodule
`default_nettype wire
